// File: rtl/rob_reclaim_queue.sv
// rob_reclaim_queue: in-order reclaim queue behind register rename.
// Each entry holds {has_dest, arch_dest, new_preg, old_preg}.
// When the head entry commits, its old preg goes back to the free list.
// When the pipeline is flushed, the entries are walked from youngest to oldest,
// and each squashed new preg goes back to the free list.
// Optional feature macro: RECLAIM_STATS_EN (commit/squash event counters).
module rob_reclaim_queue #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 5,
  parameter int AREG_W = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  logic                       dispatch_has_dest,
  input  logic [AREG_W-1:0]          dispatch_arch_dest,
  input  logic [PREG_W-1:0]          dispatch_new_preg,
  input  logic [PREG_W-1:0]          dispatch_old_preg,
  output logic [$clog2(DEPTH)-1:0]   dispatch_tag,
  input  logic                       complete_valid,
  input  logic [$clog2(DEPTH)-1:0]   complete_tag,
  input  logic                       flush,
  output logic                       commit_valid,
  output logic [AREG_W-1:0]          commit_arch_dest,
  output logic [PREG_W-1:0]          commit_new_preg,
  output logic                       return_flag,
  output logic [PREG_W-1:0]          return_reg,
  output logic                       walking
`ifdef RECLAIM_STATS_EN
  ,
  output logic [31:0]                stat_commits,
  output logic [31:0]                stat_squashes
`endif
);

  localparam int TAG_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] PTR_ONE  = {{(TAG_W-1){1'b0}}, 1'b1};
  localparam logic [TAG_W:0]   CNT_ONE  = {{TAG_W{1'b0}}, 1'b1};
  localparam logic [TAG_W:0]   CNT_ZERO = {(TAG_W+1){1'b0}};
  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);

  typedef enum logic [0:0] {RUN = 1'b0, WALK = 1'b1} state_t;

  state_t              state_r, state_nxt_s;
  logic [TAG_W-1:0]    head_r, tail_r, walk_idx_s;
  logic [TAG_W:0]      count_r, count_nxt_s;
  logic [DEPTH-1:0]    valid_r, done_r, has_dest_r;
  logic [AREG_W-1:0]   arch_r [DEPTH];
  logic [PREG_W-1:0]   new_r  [DEPTH];
  logic [PREG_W-1:0]   old_r  [DEPTH];
  logic                run_s, full_s;
  logic                dispatch_fire_s, commit_fire_s, walk_fire_s, complete_fire_s;

  // Handshake/commit/return outputs and the per-cycle event strobes.
  always_comb begin
    run_s            = (state_r == RUN);
    full_s           = (count_r == CNT_FULL);
    walk_idx_s       = tail_r - PTR_ONE;
    dispatch_ready   = run_s && !full_s;
    dispatch_tag     = tail_r;
    // Flush wins over commit, and no retirement is reported while reset is held.
    commit_valid     = !reset && run_s && valid_r[head_r] && done_r[head_r] && !flush;
    commit_arch_dest = arch_r[head_r];
    commit_new_preg  = new_r[head_r];
    walking          = !run_s;
    dispatch_fire_s  = dispatch_valid && dispatch_ready && !flush;
    commit_fire_s    = commit_valid;
    walk_fire_s      = !run_s && (count_r != CNT_ZERO);
    complete_fire_s  = complete_valid && run_s && !flush && valid_r[complete_tag];
    if (run_s) begin
      return_flag = commit_valid && has_dest_r[head_r];
      return_reg  = old_r[head_r];
    end else begin
      return_flag = !reset && walk_fire_s && has_dest_r[walk_idx_s];
      return_reg  = new_r[walk_idx_s];
    end
  end

  // Next occupancy and next state; a walk step always removes the youngest entry.
  always_comb begin
    count_nxt_s = count_r;
    state_nxt_s = state_r;
    if (walk_fire_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else if (dispatch_fire_s && !commit_fire_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!dispatch_fire_s && commit_fire_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
    case (state_r)
      RUN: begin
        if (flush && (count_r != CNT_ZERO)) begin
          state_nxt_s = WALK;
        end else begin
          state_nxt_s = RUN;
        end
      end
      WALK: begin
        if (count_r <= CNT_ONE) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = WALK;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // State, pointers and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= RUN;
      head_r  <= {TAG_W{1'b0}};
      tail_r  <= {TAG_W{1'b0}};
      count_r <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      if (commit_fire_s) begin
        head_r <= head_r + PTR_ONE;
      end
      if (walk_fire_s) begin
        tail_r <= walk_idx_s;
      end else if (dispatch_fire_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
    end
  end

  // Entry array: clear on walk/commit, fill on dispatch, mark done on complete.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r    <= {DEPTH{1'b0}};
      done_r     <= {DEPTH{1'b0}};
      has_dest_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        arch_r[i] <= {AREG_W{1'b0}};
        new_r[i]  <= {PREG_W{1'b0}};
        old_r[i]  <= {PREG_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (walk_fire_s && (walk_idx_s == TAG_W'(i))) begin
          valid_r[i] <= 1'b0;
          done_r[i]  <= 1'b0;
        end else if (commit_fire_s && (head_r == TAG_W'(i))) begin
          valid_r[i] <= 1'b0;
          done_r[i]  <= 1'b0;
        end else if (dispatch_fire_s && (tail_r == TAG_W'(i))) begin
          valid_r[i]    <= 1'b1;
          done_r[i]     <= 1'b0;
          has_dest_r[i] <= dispatch_has_dest;
          arch_r[i]     <= dispatch_arch_dest;
          new_r[i]      <= dispatch_new_preg;
          old_r[i]      <= dispatch_old_preg;
        end else if (complete_fire_s && (complete_tag == TAG_W'(i))) begin
          done_r[i] <= 1'b1;
        end
      end
    end
  end

`ifdef RECLAIM_STATS_EN
  // Event counters: retired instructions and squashed entries, wrapping at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_commits  <= 32'd0;
      stat_squashes <= 32'd0;
    end else begin
      if (commit_fire_s) begin
        stat_commits <= stat_commits + 32'd1;
      end
      if (walk_fire_s) begin
        stat_squashes <= stat_squashes + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rob_reclaim_queue.sv
// Self-checking bench for rob_reclaim_queue: a queue-based reference model
// predicts every output each cycle, plus directed literal checks.
module tb_rob_reclaim_queue;

  logic       clock, reset;
  logic       dispatch_valid, dispatch_ready, dispatch_has_dest;
  logic [4:0] dispatch_arch_dest, dispatch_new_preg, dispatch_old_preg;
  logic [3:0] dispatch_tag, complete_tag;
  logic       complete_valid, flush;
  logic       commit_valid, return_flag, walking;
  logic [4:0] commit_arch_dest, commit_new_preg, return_reg;
`ifdef RECLAIM_STATS_EN
  logic [31:0] stat_commits, stat_squashes;
`endif

  rob_reclaim_queue dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_has_dest(dispatch_has_dest), .dispatch_arch_dest(dispatch_arch_dest),
    .dispatch_new_preg(dispatch_new_preg), .dispatch_old_preg(dispatch_old_preg),
    .dispatch_tag(dispatch_tag),
    .complete_valid(complete_valid), .complete_tag(complete_tag),
    .flush(flush),
    .commit_valid(commit_valid), .commit_arch_dest(commit_arch_dest),
    .commit_new_preg(commit_new_preg),
    .return_flag(return_flag), .return_reg(return_reg),
    .walking(walking)
`ifdef RECLAIM_STATS_EN
    , .stat_commits(stat_commits), .stat_squashes(stat_squashes)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: oldest entry at index 0, youngest at the back.
  typedef struct packed {
    logic       hd;
    logic [4:0] arch;
    logic [4:0] np;
    logic [4:0] op;
    logic       done;
  } ent_t;

  ent_t mq[$];
  int   m_head = 0;
  bit   m_walk = 0;
  bit   live   = 0;

  // Model update at each active edge, from the inputs that were held over the cycle.
  always @(posedge clock) begin
    int off;
    bit do_c, do_d;
    if (reset) begin
      mq.delete();
      m_head = 0;
      m_walk = 0;
      live   = 1;
    end else if (live) begin
      if (m_walk) begin
        if (mq.size() > 0) void'(mq.pop_back());
        if (mq.size() == 0) m_walk = 0;
      end else if (flush) begin
        if (mq.size() > 0) m_walk = 1;
      end else begin
        do_c = (mq.size() > 0) && mq[0].done;
        do_d = dispatch_valid && (mq.size() < 16);
        if (complete_valid) begin
          off = (int'(complete_tag) - m_head + 16) % 16;
          if (off < mq.size()) mq[off].done = 1'b1;
        end
        if (do_c) begin
          void'(mq.pop_front());
          m_head = (m_head + 1) % 16;
        end
        if (do_d) mq.push_back('{dispatch_has_dest, dispatch_arch_dest,
                                 dispatch_new_preg, dispatch_old_preg, 1'b0});
      end
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clock) begin
    int   sz;
    logic e_commit, e_rflag;
    logic [4:0] e_rreg;
    if (live) begin
      sz = mq.size();
      e_commit = 1'b0;
      e_rflag  = 1'b0;
      e_rreg   = 5'd0;
      if (!m_walk && sz > 0) e_commit = !reset && mq[0].done && !flush;
      if (m_walk && sz > 0) begin
        e_rflag = !reset && mq[sz-1].hd;
        e_rreg  = mq[sz-1].np;
      end else if (e_commit) begin
        e_rflag = mq[0].hd;
        e_rreg  = mq[0].op;
      end
      check("m_dispatch_ready", dispatch_ready, (!m_walk && sz < 16) ? 1 : 0);
      check("m_dispatch_tag", dispatch_tag, (m_head + sz) % 16);
      check("m_walking", walking, m_walk ? 1 : 0);
      check("m_commit_valid", commit_valid, e_commit);
      if (e_commit) begin
        check("m_commit_arch", commit_arch_dest, mq[0].arch);
        check("m_commit_new", commit_new_preg, mq[0].np);
      end
      check("m_return_flag", return_flag, e_rflag);
      if (e_rflag) check("m_return_reg", return_reg, e_rreg);
    end
  end

  task automatic idle();
    dispatch_valid = 1'b0; dispatch_has_dest = 1'b0;
    dispatch_arch_dest = 5'd0; dispatch_new_preg = 5'd0; dispatch_old_preg = 5'd0;
    complete_valid = 1'b0; complete_tag = 4'd0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic disp(input logic hd, input logic [4:0] a, input logic [4:0] n, input logic [4:0] o);
    dispatch_valid = 1'b1; dispatch_has_dest = hd;
    dispatch_arch_dest = a; dispatch_new_preg = n; dispatch_old_preg = o;
  endtask

  task automatic cmpl(input logic [3:0] t);
    complete_valid = 1'b1;
    complete_tag   = t;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_ready", dispatch_ready, 1);
    check("rst_commit", commit_valid, 0);
    check("rst_rflag", return_flag, 0);
    check("rst_walking", walking, 0);
    check("rst_rreg", return_reg, 0);
    check("rst_tag", dispatch_tag, 0);

    // Single dispatch, complete, commit.
    disp(1'b1, 5'd3, 5'd7, 5'd3); tick();
    idle(); cmpl(4'd0); tick();
    idle(); #1;
    check("t1_commit", commit_valid, 1);
    check("t1_arch", commit_arch_dest, 3);
    check("t1_new", commit_new_preg, 7);
    check("t1_rflag", return_flag, 1);
    check("t1_rreg", return_reg, 3);
    tick(); #1;
    check("t1_after", commit_valid, 0);

    // Fill all 16 entries; tags 0..15; 17th refused.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      disp(1'b1, 5'(i), 5'(i + 16), 5'(i)); #1;
      check("fill_tag", dispatch_tag, i);
      tick();
    end
    idle(); #1;
    check("full_ready", dispatch_ready, 0);
    disp(1'b1, 5'd31, 5'd31, 5'd31); tick();
    idle(); #1;
    check("full_tag_wrap", dispatch_tag, 0);

    // Full queue, head done, dispatch offered in the commit cycle.
    cmpl(4'd0); tick();
    idle(); disp(1'b1, 5'd30, 5'd30, 5'd30); #1;
    check("fc_commit", commit_valid, 1);
    check("fc_ready", dispatch_ready, 0);
    tick();
    idle(); #1;
    check("fc_ready_next", dispatch_ready, 1);
    check("fc_tag_next", dispatch_tag, 0);

    // Flush the 15 remaining entries; flush/complete during the walk are ignored.
    flush = 1'b1; tick();
    idle();
    for (int k = 0; k < 15; k++) begin
      if (k == 3) begin flush = 1'b1; cmpl(4'd1); end
      else idle();
      #1;
      check("w15_walking", walking, 1);
      check("w15_rreg", return_reg, 31 - k);
      tick();
    end
    idle(); #1;
    check("w15_done", walking, 0);
    check("w15_ready", dispatch_ready, 1);

    // Out-of-order completion; middle entry has no destination.
    do_reset();
    disp(1'b1, 5'd1, 5'd11, 5'd21); tick();
    disp(1'b0, 5'd2, 5'd12, 5'd22); tick();
    disp(1'b1, 5'd3, 5'd13, 5'd23); tick();
    idle(); cmpl(4'd2); tick();
    idle(); cmpl(4'd1); tick();
    idle(); #1;
    check("ooo_wait", commit_valid, 0);
    cmpl(4'd0); tick();
    idle(); #1;
    check("ooo_c0", commit_valid, 1);
    check("ooo_c0_arch", commit_arch_dest, 1);
    check("ooo_c0_rreg", return_reg, 21);
    tick(); #1;
    check("ooo_c1", commit_valid, 1);
    check("ooo_c1_arch", commit_arch_dest, 2);
    check("ooo_c1_rflag", return_flag, 0);
    tick(); #1;
    check("ooo_c2", commit_valid, 1);
    check("ooo_c2_rreg", return_reg, 23);
    tick(); #1;
    check("ooo_empty", commit_valid, 0);

    // Three entries then flush: returns 10,9,8.
    do_reset();
    disp(1'b1, 5'd5, 5'd8, 5'd1); tick();
    disp(1'b1, 5'd6, 5'd9, 5'd2); tick();
    disp(1'b1, 5'd7, 5'd10, 5'd3); tick();
    idle(); flush = 1'b1; tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("w3_walking", walking, 1);
      check("w3_rflag", return_flag, 1);
      check("w3_rreg", return_reg, 10 - k);
      tick();
    end
    #1;
    check("w3_done", walking, 0);
    check("w3_ready", dispatch_ready, 1);
    check("w3_tag", dispatch_tag, 0);

    // Flush of an empty queue is a no-op.
    flush = 1'b1; tick();
    idle(); #1;
    check("fe_walking", walking, 0);

    // Reset in the middle of a walk.
    for (int i = 0; i < 4; i++) begin
      disp(1'b1, 5'(i), 5'(i + 4), 5'(i)); tick();
    end
    idle(); flush = 1'b1; tick();
    idle(); tick();
    reset = 1'b1; #1;
    check("rw_rflag", return_flag, 0);
    tick();
    reset = 1'b0; #1;
    check("rw_walking", walking, 0);
    check("rw_ready", dispatch_ready, 1);

    // Streaming traffic: dispatch and commit in the same cycle.
    for (int c = 0; c < 40; c++) begin
      disp((c % 3) != 0, 5'(c), 5'(c + 5), 5'(c + 9));
      if (c > 0) cmpl(4'(c - 1));
      else begin complete_valid = 1'b0; complete_tag = 4'd0; end
      tick();
    end
    idle(); cmpl(4'(39)); tick();
    idle();
    for (int c = 0; c < 4; c++) tick();
    #1;
    check("stream_drained", dispatch_tag, 8);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
